keypad_time_entry: RTL and testbench
====================================

# keypad_time_entry

Cooking-time entry and timer-load controller for the microwave. It collects BCD digits from the keypad decoder into an MM:SS buffer, validates the buffer on START, and drives the load side of the BCD countdown chain. The chain is the sec-ones mod-10, sec-tens mod-6, min-ones and min-tens counters. The block then holds the chain enabled until it reports zero or the user presses CLEAR.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- clrn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code valid while high.
- key_code  in  4  key value; 0–9 are digits, 10–15 are ignored.
- clear_key  in  1  one-cycle CLEAR strobe.
- start_key  in  1  one-cycle START strobe.
- timer_zero  in  1  high when every countdown digit is 0.
- data  out  16  {min_tens, min_ones, sec_tens, sec_ones} BCD, wired to the counters' data inputs.
- loadn  out  1  active-low load strobe to the counters; registered and glitch-free.
- en  out  1  countdown enable to the counter chain.
- digits  out  3  number of digits entered, 0–4.
- err  out  1  one-cycle pulse when START is rejected.
- done  out  1  one-cycle pulse when the countdown reaches zero.

## Operation
- States: IDLE, ENTRY, LOAD, RUN.
- Event priority within one cycle: clear_key > start_key > key_valid.
- IDLE:
  - Buffer is 0000, digits = 0, en = 0.
  - A valid digit (key_valid with key_code ≤ 9) does a shift-in and moves to ENTRY.
  - start_key and clear_key have no effect.
- Shift-in:
  - sec_ones ← key_code, sec_tens ← old sec_ones, min_ones ← old sec_tens, min_tens ← old min_ones.
  - digits increments.
- ENTRY:
  - A valid digit shifts in while digits < 4. When digits = 4, further digits are ignored and the buffer is unchanged.
  - key_code 10–15 is ignored in every state.
  - clear_key zeroes the buffer, sets digits = 0 and returns to IDLE.
  - start_key with sec_tens ≤ 5 and buffer ≠ 0000 moves to LOAD.
  - start_key with sec_tens > 5 or buffer = 0000 pulses err. The state stays ENTRY and the buffer is unchanged.
- LOAD:
  - loadn = 0 for exactly one cycle while data holds the buffer.
  - Next state is RUN unconditionally. key, start and clear inputs are ignored in LOAD.
- RUN:
  - en = 1. Digit and start keys are ignored.
  - clear_key sets en = 0, zeroes the buffer, sets digits = 0 and returns to IDLE with no done pulse.
  - timer_zero = 1 pulses done, sets en = 0, zeroes the buffer, sets digits = 0 and returns to IDLE.
  - If clear_key and timer_zero occur together, clear wins and done is not pulsed.
- The data outputs always reflect the buffer. They are frozen from LOAD through RUN, because the buffer is not modified there.
- Minutes are not range-checked. 99:59 is the maximum valid entry.

## Timing
- Reset values: state IDLE, data = 0x0000, loadn = 1, en = 0, digits = 0, err = 0, done = 0.
- Reset asserted mid-LOAD or mid-RUN immediately forces loadn = 1 and en = 0.
- A digit strobe at edge N is visible on data and digits after edge N.
- START accepted at edge N:
  - LOAD spans cycle N to N+1, with loadn low.
  - RUN begins at edge N+1, with en = 1.
  - Total latency from START to en is 2 edges.
- timer_zero sampled high at edge M in RUN: done is high and en is low during cycle M to M+1; IDLE begins at M.
- err and done are single-cycle pulses and are never asserted in the same cycle.
- All outputs are driven from registers. There is no combinational path from any input to any output.

## Test plan
- Reset, then keys 1,2,3,0 and START:
  - data = 0x1230, digits = 4.
  - loadn low for exactly 1 cycle, 1 edge after START.
  - en = 1 from the next edge.
- Keys 9,9 then START: err pulses once (sec_tens = 9), the state stays ENTRY and data = 0x0099. Then CLEAR: data = 0x0000, digits = 0, back to IDLE.
- Keys 1,2,3,4,5 then key 0xB: data = 0x1234. The 5th digit and the code 0xB are both ignored.
- From RUN, assert timer_zero: done pulses one cycle, en = 0 the same cycle, then IDLE with data = 0.
- In ENTRY, clear_key and start_key in the same cycle: CLEAR wins, with no LOAD and no err. In RUN, clear_key and timer_zero in the same cycle: en drops and done stays 0.
- Drop clrn mid-RUN, asynchronous to clk: en = 0, loadn = 1 and data = 0 before the next edge. START in IDLE then has no effect.

Source files
------------

// File: rtl/keypad_time_entry_if.sv
// Signal bundle between the keypad/timer side and keypad_time_entry.
// The master side drives key and timer status; the slave side drives the counter load/enable.
interface keypad_time_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        clear_key;
    logic        start_key;
    logic        timer_zero;
    logic [15:0] data;
    logic        loadn;
    logic        en;
    logic [2:0]  digits;
    logic        err;
    logic        done;

    modport master (
        output key_valid, key_code, clear_key, start_key, timer_zero,
        input  data, loadn, en, digits, err, done
    );

    modport slave (
        input  key_valid, key_code, clear_key, start_key, timer_zero,
        output data, loadn, en, digits, err, done
    );
endinterface

// File: rtl/keypad_time_entry.sv
// Microwave cooking-time entry: collects BCD keys into an MM:SS buffer, validates on START,
// pulses a one-cycle load into the countdown chain and holds it enabled until zero or CLEAR.
module keypad_time_entry (
    input  logic              clk,
    input  logic              clrn,
    keypad_time_entry_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    // Seconds tens must be a legal 0-5 digit and a zero time is never started.
    function automatic logic entry_ok(input logic [15:0] buf_v);
        return (buf_v[7:4] <= 4'd5) && (buf_v != 16'h0000);
    endfunction

    function automatic logic [15:0] shift_in(input logic [15:0] buf_v, input logic [3:0] d);
        return {buf_v[11:0], d};
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [15:0] buf_r;
    logic [15:0] buf_nxt_s;
    logic [2:0]  digits_r;
    logic [2:0]  digits_nxt_s;
    logic        loadn_r;
    logic        loadn_nxt_s;
    logic        en_r;
    logic        en_nxt_s;
    logic        err_r;
    logic        err_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic        digit_key_s;

    assign digit_key_s = bus.key_valid && is_digit(bus.key_code);

    // Next-state, buffer and pulse decode with clear > start > key priority.
    always_comb begin
        state_nxt_s  = state_r;
        buf_nxt_s    = buf_r;
        digits_nxt_s = digits_r;
        err_nxt_s    = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear_key || bus.start_key) begin
                    state_nxt_s = ST_IDLE;
                end else if (digit_key_s) begin
                    buf_nxt_s    = shift_in(16'h0000, bus.key_code);
                    digits_nxt_s = 3'd1;
                    state_nxt_s  = ST_ENTRY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (bus.clear_key) begin
                    buf_nxt_s    = 16'h0000;
                    digits_nxt_s = 3'd0;
                    state_nxt_s  = ST_IDLE;
                end else if (bus.start_key) begin
                    if (entry_ok(buf_r)) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else if (digit_key_s) begin
                    if (digits_r < 3'd4) begin
                        buf_nxt_s    = shift_in(buf_r, bus.key_code);
                        digits_nxt_s = digits_r + 3'd1;
                    end else begin
                        buf_nxt_s = buf_r;
                    end
                end else begin
                    state_nxt_s = ST_ENTRY;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                // A simultaneous CLEAR suppresses the done pulse.
                if (bus.clear_key) begin
                    buf_nxt_s    = 16'h0000;
                    digits_nxt_s = 3'd0;
                    state_nxt_s  = ST_IDLE;
                end else if (bus.timer_zero) begin
                    buf_nxt_s    = 16'h0000;
                    digits_nxt_s = 3'd0;
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                buf_nxt_s    = 16'h0000;
                digits_nxt_s = 3'd0;
                state_nxt_s  = ST_IDLE;
            end
        endcase
        loadn_nxt_s = (state_nxt_s != ST_LOAD);
        en_nxt_s    = (state_nxt_s == ST_RUN);
    end

    // State and output registers; reset forces the counters out of load and run at once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r  <= ST_IDLE;
            buf_r    <= 16'h0000;
            digits_r <= 3'd0;
            loadn_r  <= 1'b1;
            en_r     <= 1'b0;
            err_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            buf_r    <= buf_nxt_s;
            digits_r <= digits_nxt_s;
            loadn_r  <= loadn_nxt_s;
            en_r     <= en_nxt_s;
            err_r    <= err_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign bus.data   = buf_r;
    assign bus.digits = digits_r;
    assign bus.loadn  = loadn_r;
    assign bus.en     = en_r;
    assign bus.err    = err_r;
    assign bus.done   = done_r;

    keypad_time_entry_chk u_chk (
        .clk    (clk),
        .clrn   (clrn),
        .loadn  (loadn_r),
        .en     (en_r),
        .err    (err_r),
        .done   (done_r),
        .digits (digits_r)
    );
endmodule

// Protocol invariants on the counter-side outputs.
module keypad_time_entry_chk (
    input logic       clk,
    input logic       clrn,
    input logic       loadn,
    input logic       en,
    input logic       err,
    input logic       done,
    input logic [2:0] digits
);
    a_err_done_excl: assert property (@(posedge clk) disable iff (!clrn) !(err && done));
    a_digits_max:    assert property (@(posedge clk) disable iff (!clrn) digits <= 3'd4);
    a_load_single:   assert property (@(posedge clk) disable iff (!clrn) !loadn |=> loadn);
    a_load_to_run:   assert property (@(posedge clk) disable iff (!clrn) !loadn |=> en);
    a_load_not_run:  assert property (@(posedge clk) disable iff (!clrn) !(en && !loadn));
    a_done_pulse:    assert property (@(posedge clk) disable iff (!clrn) done |=> !done);
endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: directed scenarios plus random keys against a digit-queue model.
module tb_keypad_time_entry;
    logic clk;
    logic clrn;
    keypad_time_entry_if bus();

    keypad_time_entry dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model: phase 0 idle, 1 entry, 2 load, 3 run; entered digits kept oldest-first.
    int m_phase;
    int m_q[$];
    bit m_err;
    bit m_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_data();
        logic [15:0] v;
        v = 16'h0000;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    function automatic bit entry_accepts();
        int n;
        int sec_tens;
        bit nonzero;
        n = m_q.size();
        sec_tens = (n >= 2) ? m_q[n-2] : 0;
        nonzero = 1'b0;
        foreach (m_q[i]) if (m_q[i] != 0) nonzero = 1'b1;
        return nonzero && (sec_tens <= 5);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_q.delete();
        m_err = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        int ph;
        bit is_dig;
        ph = m_phase;
        is_dig = bus.key_valid && (bus.key_code < 4'd10);
        m_err = 1'b0;
        m_done = 1'b0;
        if (ph == 0) begin
            if (!bus.clear_key && !bus.start_key && is_dig) begin
                m_q.delete();
                m_q.push_back(int'(bus.key_code));
                m_phase = 1;
            end
        end else if (ph == 1) begin
            if (bus.clear_key) begin
                m_q.delete();
                m_phase = 0;
            end else if (bus.start_key) begin
                if (entry_accepts()) m_phase = 2;
                else m_err = 1'b1;
            end else if (is_dig && m_q.size() < 4) begin
                m_q.push_back(int'(bus.key_code));
            end
        end else if (ph == 2) begin
            m_phase = 3;
        end else begin
            if (bus.clear_key) begin
                m_q.delete();
                m_phase = 0;
            end else if (bus.timer_zero) begin
                m_q.delete();
                m_phase = 0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("data",   bus.data,           exp_data());
            chk("digits", 16'(bus.digits),    16'(m_q.size()));
            chk("loadn",  16'(bus.loadn),     (m_phase == 2) ? 16'd0 : 16'd1);
            chk("en",     16'(bus.en),        (m_phase == 3) ? 16'd1 : 16'd0);
            chk("err",    16'(bus.err),       16'(m_err));
            chk("done",   16'(bus.done),      16'(m_done));
        end
    end

    task automatic step(input bit kv, input logic [3:0] kc, input bit clr, input bit st, input bit tz);
        bus.key_valid  = kv;
        bus.key_code   = kc;
        bus.clear_key  = clr;
        bus.start_key  = st;
        bus.timer_zero = tz;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start();
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        clrn = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code = 4'd0;
        bus.clear_key = 1'b0;
        bus.start_key = 1'b0;
        bus.timer_zero = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_data",   bus.data,          16'h0000);
        chk("rst_loadn",  16'(bus.loadn),    16'd1);
        chk("rst_en",     16'(bus.en),       16'd0);
        chk("rst_digits", 16'(bus.digits),   16'd0);
        chk("rst_err",    16'(bus.err),      16'd0);
        chk("rst_done",   16'(bus.done),     16'd0);
        clrn = 1'b1;
        chk_on = 1'b1;

        // 1,2,3,0 then START, run to zero
        key(4'd1); key(4'd2); key(4'd3); key(4'd0);
        chk("t1_data",    bus.data,          16'h1230);
        chk("t1_model",   exp_data(),        16'h1230);
        chk("t1_digits",  16'(bus.digits),   16'd4);
        start();
        chk("t1_loadn_lo", 16'(bus.loadn),   16'd0);
        chk("t1_en_lo",    16'(bus.en),      16'd0);
        idle();
        chk("t1_loadn_hi", 16'(bus.loadn),   16'd1);
        chk("t1_en_hi",    16'(bus.en),      16'd1);
        repeat (3) idle();
        chk("t1_run_data", bus.data,         16'h1230);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_done",     16'(bus.done),    16'd1);
        chk("t1_done_en",  16'(bus.en),      16'd0);
        chk("t1_done_data", bus.data,        16'h0000);
        idle();
        chk("t1_done_end", 16'(bus.done),    16'd0);

        // 9,9 START rejected, then CLEAR
        key(4'd9); key(4'd9);
        start();
        chk("t2_err",      16'(bus.err),     16'd1);
        chk("t2_model_err", 16'(m_err),      16'd1);
        chk("t2_data",     bus.data,         16'h0099);
        idle();
        chk("t2_err_end",  16'(bus.err),     16'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("t2_clr_data", bus.data,         16'h0000);
        chk("t2_clr_dig",  16'(bus.digits),  16'd0);

        // fifth digit and code 0xB ignored; then CLEAR+START together
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        key(4'hB);
        chk("t3_data",     bus.data,         16'h1234);
        chk("t3_model",    exp_data(),       16'h1234);
        step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("t3_cs_err",   16'(bus.err),     16'd0);
        chk("t3_cs_loadn", 16'(bus.loadn),   16'd1);
        chk("t3_cs_dig",   16'(bus.digits),  16'd0);

        // CLEAR and timer_zero together in RUN
        key(4'd5); start(); idle();
        chk("t4_en",       16'(bus.en),      16'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("t4_en_off",   16'(bus.en),      16'd0);
        chk("t4_no_done",  16'(bus.done),    16'd0);

        // asynchronous reset mid-RUN, then START in IDLE
        key(4'd7); start(); idle();
        chk("t5_en",       16'(bus.en),      16'd1);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_en",    16'(bus.en),     16'd0);
        chk("t5_rst_loadn", 16'(bus.loadn),  16'd1);
        chk("t5_rst_data",  bus.data,        16'h0000);
        @(negedge clk);
        clrn = 1'b1;
        start();
        chk("t5_st_loadn", 16'(bus.loadn),   16'd1);
        chk("t5_st_en",    16'(bus.en),      16'd0);
        chk("t5_st_err",   16'(bus.err),     16'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit kv;
            bit clr;
            bit st;
            bit tz;
            logic [3:0] kc;
            kv  = ($urandom_range(0, 99) < 40);
            kc  = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 99) < 4);
            st  = ($urandom_range(0, 99) < 12);
            tz  = ($urandom_range(0, 99) < 8);
            step(kv, kc, clr, st, tz);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
